sha256_stream_padder: RTL and testbench
=======================================

// Module: sha256_stream_padder
// PURPOSE
//  Parametrised SHA-256 message front end: accepts a byte-oriented input stream IN_W bits wide, packs it
//  big-endian into 32-bit words and appends FIPS 180-4 padding (0x80, zero fill, 64-bit bit length).
//  Emits complete 16-word blocks on a valid/ready word stream for the compression core.
//  Successor to the fixed 8-bit loader in the Tiny Tapeout SHA-256 wrapper: adds selectable beat width,
//  partial last beat, automatic padding, multi-block messages and output back-pressure.
// PARAMETERS
//  IN_W   8   input beat width in bits; legal values 8, 16, 32 (elaboration error otherwise)
//  LEN_W  32  message byte-counter width; bit-length field = {zeros, bytes<<3}, upper bits zero-extended
// PORTS
//  clk        in   1          clock; all logic on rising edge
//  rst        in   1          synchronous reset, active high
//  in_valid   in   1          input beat valid
//  in_data    in   IN_W       beat data; first byte in MSBs
//  in_last    in   1          beat is the final one of the message
//  in_nbytes  in   $clog2(IN_W/8+1)  valid bytes in last beat, 0..IN_W/8, MSB-aligned; ignored unless in_last
//  in_ready   out  1          beat accepted when in_valid & in_ready
//  out_valid  out  1          out_word valid
//  out_word   out  32         block word, big-endian bytes
//  out_first  out  1          word index 0 of a block
//  out_blast  out  1          word index 15 of a block
//  out_mend   out  1          word 15 of the final block of the message
//  out_ready  in   1          consumer accepts word when out_valid & out_ready
//  len_ovf    out  1          sticky: byte count wrapped 2^LEN_W; cleared by rst or next message start
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1 the cycle after rst deasserts; state IDLE; counters, buffer cleared.
//  Reset mid-message discards partial data and any held output word; out_valid low the cycle after rst.
//  FSM: IDLE -> ABSORB on first accepted beat (or on in_last with in_nbytes=0: empty message -> PAD80).
//   ABSORB: bytes shifted into word buffer at byte index bi (0..3); word index wi (0..15); byte count += bytes.
//   On in_last -> PAD80: inserts 0x80 at next byte position.
//   PADZ: zero bytes until byte position in block == 56; if position was >56 after 0x80, zero to 64,
//   new block, then zero to 56. LENHI emits {zeros,len[63:32]}, LENLO emits len[31:0] -> IDLE.
//  Bit length = byte_count*8 computed once at in_last; width LEN_W+3 zero-extended to 64.
//  One output word register; word emitted when bi wraps 3->0; in_ready=0 while register full and
//   out_ready=0, and in every state other than IDLE/ABSORB. Output accepted and a new word filled same cycle:
//   allowed, no bubble.
//  out_valid held, out_word/flags stable until handshake; never retracted without handshake.
//  Throughput: IN_W/8 bytes per cycle in, at most one word per cycle out; padding 1 word/cycle.
//  out_first/out_blast from wi; out_mend only with LENLO word. wi wraps 15->0 on handshake.
//  Partial last beat: only top in_nbytes bytes used; IN_W/8 never straddles a word boundary.
//  Next message may start in IDLE the cycle after the LENLO handshake; no inter-message bubble required.
//  in_valid with in_last and nbytes=0 in ABSORB: legal, ends message with no extra data.
// STRUCTURE
//  sha256_pkg: typedef enum pad_state_t {IDLE,ABSORB,PAD80,PADZ,LENHI,LENLO}; PAD_BYTE=8'h80;
//   WORDS_PER_BLK=16; LEN_POS_BYTE=56.
//  Sub-module sha256_word_packer (IN_W beats -> 32-bit word, bi counter, byte insert port for pad bytes);
//   top holds FSM, length counter, block counters, output register.
// TESTING
//  IN_W=8, bytes 61 62 63, last nbytes=1 -> 61626380, 13x00000000, 00000000, 00000018; out_mend on w15.
//  Empty message (in_last, nbytes=0) -> 80000000, 14x00000000, 00000000; out_mend on w15.
//  IN_W=32, 55 bytes of 0xAA (last nbytes=3) -> one block, w13=AAAAAA80, w15=000001B8.
//  IN_W=32, 56 bytes -> two blocks: blk1 w14=80000000, w15=0; blk2 w0..14=0, w15=000001C0, out_mend.
//  IN_W=16, "abc" with random out_ready (30% duty) -> identical word sequence as test 1; no drop/duplication.
//  Reset asserted mid-"abc", then "abc" again -> only one clean block as test 1; len_ovf stays 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 stream padder.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD80,
        PADZ,
        LENHI,
        LENLO
    } pad_state_t;

    localparam logic [7:0]  PAD_BYTE      = 8'h80;
    localparam int unsigned WORDS_PER_BLK = 16;
    localparam int unsigned LEN_POS_BYTE  = 56;

endpackage

// File: rtl/sha256_word_packer.sv
// Packs MSB-first input bytes into a 32-bit word; also inserts the 0x80 pad byte
// and zero-fills the rest of the current word in a single write.
module sha256_word_packer
    import sha256_pkg::*;
#(
    parameter int IN_W = 8,
    localparam int NB_W = $clog2(IN_W / 8 + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            beat_en,
    input  logic [IN_W-1:0] beat_data,
    input  logic [NB_W-1:0] beat_nb,
    input  logic            pad_en,
    output logic [31:0]     word,
    output logic            word_done
);

    logic [31:0] word_q;
    logic [1:0]  bi;
    logic [31:0] beat_msb;
    logic [31:0] keep_mask;
    logic [31:0] merged;
    logic [2:0]  bi_sum;

    always_comb begin
        beat_msb  = 32'(beat_data) << (32 - IN_W);
        keep_mask = ~(32'hFFFF_FFFF >> (8 * beat_nb));
        merged    = word_q;
        bi_sum    = {1'b0, bi};
        if (pad_en) begin
            // Pad byte lands at bi; bytes below stay zero, so the word is complete.
            merged = word_q | ((32'(PAD_BYTE) << 24) >> (8 * bi));
            bi_sum = 3'd4;
        end else if (beat_en) begin
            merged = word_q | ((beat_msb & keep_mask) >> (8 * bi));
            bi_sum = {1'b0, bi} + 3'(beat_nb);
        end
    end

    assign word      = merged;
    assign word_done = (pad_en || beat_en) && (bi_sum == 3'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            bi     <= '0;
        end else if (word_done) begin
            word_q <= '0;
            bi     <= '0;
        end else if (beat_en) begin
            word_q <= merged;
            bi     <= bi_sum[1:0];
        end
    end

endmodule

// File: rtl/sha256_stream_padder.sv
// SHA-256 message front end: packs a byte stream into 32-bit words, appends
// FIPS 180-4 padding and emits 16-word blocks on a valid/ready stream.
module sha256_stream_padder
    import sha256_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int LEN_W = 32,
    localparam int NB_W = $clog2(IN_W / 8 + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_last,
    input  logic [NB_W-1:0] in_nbytes,
    output logic            in_ready,
    output logic            out_valid,
    output logic [31:0]     out_word,
    output logic            out_first,
    output logic            out_blast,
    output logic            out_mend,
    input  logic            out_ready,
    output logic            len_ovf
);

    localparam int CNT_W = LEN_W + 1;
    localparam logic [3:0] LAST_WI      = 4'(WORDS_PER_BLK - 1);
    localparam logic [3:0] LAST_ZERO_WI = 4'(LEN_POS_BYTE / 4 - 1);

    if (!(IN_W == 8 || IN_W == 16 || IN_W == 32)) begin : g_bad_in_w
        $error("sha256_stream_padder: IN_W must be 8, 16 or 32");
    end
    if (LEN_W < 1 || LEN_W > 61) begin : g_bad_len_w
        $error("sha256_stream_padder: LEN_W must be 1..61");
    end

    pad_state_t        state;
    pad_state_t        state_nxt;
    logic [3:0]        wi;
    logic [LEN_W-1:0]  byte_cnt;
    logic [63:0]       bit_len;
    logic              can_load;
    logic              absorbing;
    logic              beat_fire;
    logic              pad_fire;
    logic [NB_W-1:0]   beat_nb;
    logic [LEN_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_sum;
    logic [31:0]       pk_word;
    logic              pk_done;
    logic              ld_en;
    logic [31:0]       ld_word;
    logic              ld_mend;

    assign can_load  = !out_valid || out_ready;
    assign absorbing = (state == IDLE) || (state == ABSORB);
    assign in_ready  = !rst && absorbing && can_load;
    assign beat_fire = in_valid && in_ready;
    assign pad_fire  = (state == PAD80) && can_load;
    assign beat_nb   = in_last ? in_nbytes : NB_W'(IN_W / 8);
    assign cnt_base  = (state == IDLE) ? '0 : byte_cnt;
    assign cnt_sum   = {1'b0, cnt_base} + CNT_W'(beat_nb);

    sha256_word_packer #(
        .IN_W(IN_W)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .beat_en  (beat_fire),
        .beat_data(in_data),
        .beat_nb  (beat_nb),
        .pad_en   (pad_fire),
        .word     (pk_word),
        .word_done(pk_done)
    );

    always_comb begin
        ld_en     = 1'b0;
        ld_word   = '0;
        ld_mend   = 1'b0;
        state_nxt = state;
        case (state)
            IDLE, ABSORB: begin
                if (beat_fire) begin
                    ld_en     = pk_done;
                    ld_word   = pk_word;
                    state_nxt = in_last ? PAD80 : ABSORB;
                end
            end
            PAD80: begin
                if (can_load) begin
                    ld_en     = 1'b1;
                    ld_word   = pk_word;
                    state_nxt = (wi == LAST_ZERO_WI) ? LENHI : PADZ;
                end
            end
            PADZ: begin
                // Runs past the block end when the 0x80 word landed beyond byte 56.
                if (can_load) begin
                    ld_en     = 1'b1;
                    state_nxt = (wi == LAST_ZERO_WI) ? LENHI : PADZ;
                end
            end
            LENHI: begin
                if (can_load) begin
                    ld_en     = 1'b1;
                    ld_word   = bit_len[63:32];
                    state_nxt = LENLO;
                end
            end
            LENLO: begin
                if (can_load) begin
                    ld_en     = 1'b1;
                    ld_word   = bit_len[31:0];
                    ld_mend   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wi        <= '0;
            byte_cnt  <= '0;
            bit_len   <= '0;
            len_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_first <= 1'b0;
            out_blast <= 1'b0;
            out_mend  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (beat_fire) begin
                byte_cnt <= cnt_sum[LEN_W-1:0];
                len_ovf  <= (state == IDLE) ? cnt_sum[LEN_W] : (len_ovf | cnt_sum[LEN_W]);
                if (in_last) begin
                    bit_len <= 64'({cnt_sum[LEN_W-1:0], 3'b000});
                end
            end
            if (ld_en) begin
                out_valid <= 1'b1;
                out_word  <= ld_word;
                out_first <= (wi == 4'd0);
                out_blast <= (wi == LAST_WI);
                out_mend  <= ld_mend;
                wi        <= wi + 4'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Randomised bench for sha256_stream_padder at IN_W = 8, 16 and 32 against a
// byte-level padding model.
module tb_sha256_stream_padder;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic [31:0] d;
    logic        lst;
    logic [2:0]  nb;
    logic        vld [3];
    logic        rdy [3];
    logic        ov  [3];
    logic        of  [3];
    logic        ob  [3];
    logic        om  [3];
    logic        lo  [3];
    logic [31:0] ow  [3];

    int          n_total = 0;
    int          n_bad   = 0;
    int          sel     = 0;
    logic [7:0]  msg_q[$];
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    sha256_stream_padder #(.IN_W(8), .LEN_W(32)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(d[31:24]), .in_last(lst),
        .in_nbytes(nb[0:0]), .in_ready(rdy[0]), .out_valid(ov[0]), .out_word(ow[0]),
        .out_first(of[0]), .out_blast(ob[0]), .out_mend(om[0]), .out_ready(out_ready),
        .len_ovf(lo[0])
    );

    sha256_stream_padder #(.IN_W(16), .LEN_W(32)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(d[31:16]), .in_last(lst),
        .in_nbytes(nb[1:0]), .in_ready(rdy[1]), .out_valid(ov[1]), .out_word(ow[1]),
        .out_first(of[1]), .out_blast(ob[1]), .out_mend(om[1]), .out_ready(out_ready),
        .len_ovf(lo[1])
    );

    sha256_stream_padder #(.IN_W(32), .LEN_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_data(d), .in_last(lst),
        .in_nbytes(nb), .in_ready(rdy[2]), .out_valid(ov[2]), .out_word(ow[2]),
        .out_first(of[2]), .out_blast(ob[2]), .out_mend(om[2]), .out_ready(out_ready),
        .len_ovf(lo[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected words from the padding rules: msg, 0x80, zeros to 56 mod 64, 64-bit bit length.
    task automatic build_exp();
        logic [7:0]  p[$];
        logic [63:0] bl;
        int          nw;
        exp_q.delete();
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nw = p.size() / 4;
        for (int k = 0; k < nw; k++)
            exp_q.push_back({k == nw - 1, k % 16 == 15, k % 16 == 0,
                             p[4*k], p[4*k+1], p[4*k+2], p[4*k+3]});
    endtask

    task automatic drive(input bit extra_empty);
        int bpb;
        int len;
        int idx;
        int rem;
        int n;
        int w;
        bit last;
        bit done;
        bpb  = 1 << sel;
        len  = msg_q.size();
        idx  = 0;
        done = 0;
        while (!done) begin
            rem = len - idx;
            if (rem > bpb || (rem == bpb && extra_empty)) begin
                n = bpb; last = 0;
            end else begin
                n = rem; last = 1;
            end
            if ($urandom_range(4) == 0) begin
                @(negedge clk);
                vld[sel] = 1'b0;
            end
            @(negedge clk);
            d = $urandom;
            for (int j = 0; j < n; j++) d[31-8*j -: 8] = msg_q[idx+j];
            lst      = last;
            nb       = 3'(n);
            vld[sel] = 1'b1;
            #1;
            w = 0;
            while (!rdy[sel] && w < 1000) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (!rdy[sel]) begin
                chk("in_stall", 64'd0, 64'd1);
                done = 1;
            end else begin
                @(posedge clk);
                idx += n;
                if (last) done = 1;
            end
        end
        @(negedge clk);
        vld[sel] = 1'b0;
        lst      = 1'b0;
    endtask

    task automatic collect(input int duty);
        int          k;
        int          cyc;
        bit          held;
        logic [34:0] hv;
        logic [34:0] cur;
        k    = 0;
        cyc  = 0;
        held = 0;
        hv   = '0;
        while (k < exp_q.size() && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            cur = {om[sel], ob[sel], of[sel], ow[sel]};
            if (held) chk("hold", {ov[sel], cur}, {1'b1, hv});
            out_ready = ($urandom_range(99) < duty);
            if (ov[sel]) begin
                if (out_ready) begin
                    chk($sformatf("word%0d", k), cur, exp_q[k]);
                    k++;
                    held = 0;
                end else begin
                    held = 1;
                    hv   = cur;
                end
            end else begin
                held = 0;
            end
        end
        if (k < exp_q.size()) chk("out_timeout", 64'(k), 64'(exp_q.size()));
        out_ready = 1'b1;
        @(negedge clk);
        chk("no_extra", 64'(ov[sel]), 64'd0);
        chk("len_ovf", 64'(lo[sel]), 64'd0);
    endtask

    task automatic run_msg(input int s, input int duty, input bit extra_empty);
        sel = s;
        build_exp();
        fork
            drive(extra_empty);
            collect(duty);
        join
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        d         = '0;
        lst       = 1'b0;
        nb        = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready%0d", i), 64'(rdy[i]), 64'd1);
            chk($sformatf("rst_out%0d", i),
                {ov[i], of[i], ob[i], om[i], lo[i], ow[i]}, 64'd0);
        end

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(0, 100, 0);

        msg_q.delete();
        run_msg(0, 100, 0);

        msg_q.delete();
        repeat (55) msg_q.push_back(8'hAA);
        run_msg(2, 100, 0);

        msg_q.push_back(8'hAA);
        run_msg(2, 100, 0);

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(1, 30, 0);

        // Held output word under back-pressure, then reset drops it.
        sel       = 2;
        out_ready = 1'b0;
        @(negedge clk);
        d = 32'h41424344; lst = 1'b0; nb = 3'd4; vld[2] = 1'b1;
        @(negedge clk);
        vld[2] = 1'b0;
        @(negedge clk);
        chk("held_valid", 64'(ov[2]), 64'd1);
        chk("held_word", 64'(ow[2]), 64'h41424344);
        chk("held_ready", 64'(rdy[2]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_drop", 64'(ov[2]), 64'd0);
        out_ready = 1'b1;

        // Partial "ab" discarded by reset, then a full "abc".
        sel = 0;
        @(negedge clk);
        d = 32'h61000000; lst = 1'b0; nb = 3'd1; vld[0] = 1'b1;
        @(negedge clk);
        d = 32'h62000000;
        @(negedge clk);
        vld[0] = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(0, 100, 0);

        for (int r = 0; r < 24; r++) begin
            int len;
            len = $urandom_range(140);
            msg_q.delete();
            for (int b = 0; b < len; b++) msg_q.push_back(8'($urandom));
            run_msg($urandom_range(2), $urandom_range(100, 30), 1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
